pipe_out_fifo: RTL and testbench
================================

# pipe_out_fifo

Output buffer that sits directly downstream of the 3-stage increment pipeline (in → x → y → z, out = in + 2 after 3 clocks). The pipeline has no stall path, so this block captures every valid result into a small FIFO and presents it to the consumer over a valid/ready handshake. On full, it drops the incoming word and records the loss in a sticky flag and a drop counter.

## Interface
- DWIDTH, 4, data width; matches pipeline `out`.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CWIDTH, $clog2(DEPTH)+1, width of `count`; derived, not overridden.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream word present this cycle (valid bit carried alongside `z`).
- in_data  in  DWIDTH  pipeline `out`.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head word this cycle.
- out_data  out  DWIDTH  head word; 0 when empty.
- count  out  CWIDTH  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a word was dropped since last clear.
- drop_count  out  8  words dropped; saturates at 255.
- clear_ovf  in  1  clears `overflow` and `drop_count`.

## Operation
- Storage: DEPTH × DWIDTH register array. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in `count`.
- pop = out_valid & out_ready.
- push = in_valid & (count < DEPTH | pop).
- drop = in_valid & (count == DEPTH) & ~pop.
- push writes in_data at wr_ptr, then wr_ptr+1.
- pop advances rd_ptr+1.
- count next = count + push − pop.
- Full, push and pop together: both happen, count stays at DEPTH, no drop.
- Empty with in_valid: word is written. out_valid rises next cycle. No combinational bypass; empty-state pop is impossible because out_valid = 0.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0. Both come from registers only, with no path from in_* to out_*.
- drop sets `overflow` and increments `drop_count` (saturating).
- clear_ovf clears both. If drop and clear_ovf occur in the same cycle: overflow = 1, drop_count = 1.
- out_ready while empty: ignored.
- in_valid = 0: in_data is ignored.
- Arithmetic: all pointer and count math is unsigned. Pointer wrap relies on power-of-two DEPTH. count never exceeds DEPTH or goes below 0.

## Timing
- Reset values: out_valid 0, out_data 0, count 0, overflow 0, drop_count 0, rd_ptr 0, wr_ptr 0. Array contents need not be cleared.
- Reset asserted mid-operation: all outputs return to reset values asynchronously, without waiting for a clock edge. Buffered words are discarded. First push after reset deassertion behaves as from empty.
- Write-to-visible latency: 1 cycle. A word accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: 1 push and 1 pop per cycle sustained at any occupancy.
- Handshake: out_data and out_valid are stable while out_valid = 1 and out_ready = 0. Consumer may hold out_ready high continuously.
- End-to-end latency from pipeline `in` to out_data with no backpressure: 3 (pipeline) + 1 = 4 cycles.

## Test plan
- Reset then idle: assert reset mid-cycle with count = 2 → all outputs 0 before the next edge. They stay 0 after release while in_valid = 0.
- Fill/drain: out_ready = 0, push 0x2, 0x3, 0x4, 0x5 → count 4, out_data 0x2. Raise out_ready → pops 0x2, 0x3, 0x4, 0x5 in order, then out_valid = 0, out_data = 0.
- Overflow: with FIFO full and out_ready = 0, push 0xA, 0xB → overflow = 1, drop_count = 2, contents unchanged. Pulse clear_ovf → both 0. Same-cycle drop + clear_ovf → overflow 1, drop_count 1.
- Full with simultaneous push/pop: full with head 0x2, in_valid = 1, in_data = 0x9, out_ready = 1 → count stays 4, no drop. After 4 pops, 0x9 is last out.
- Streaming with pipeline attached: drive pipeline in = 0..15 continuously with out_ready = 1 → out_data = 0x2..0xF, 0x0, 0x1 (4-bit wrap). First value appears 4 cycles after in = 0. count ≤ 1 throughout.
- Saturation and pointer wrap: force 300 drops → drop_count = 255. Run 3×DEPTH push/pop pairs across wrap → data order preserved.

Source files
------------

// File: rtl/pipe_out_fifo.sv
// Output buffer behind the 3-stage increment pipeline: captures every valid result
// into a small FIFO, serves it over valid/ready, and counts words lost when full.
module pipe_out_fifo #(
  parameter int DWIDTH = 4,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [CWIDTH-1:0] count,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              clear_ovf
);

  localparam int AWIDTH = $clog2(DEPTH);
  localparam logic [CWIDTH-1:0] FULL_COUNT = CWIDTH'(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_rdPtr;
  logic [AWIDTH-1:0] r_wrPtr;
  logic [CWIDTH-1:0] r_count;
  logic              r_overflow;
  logic [7:0]        r_dropCount;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts then.
  assign w_full = (r_count == FULL_COUNT);
  assign w_pop  = (r_count != '0) & out_ready;
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AWIDTH'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AWIDTH'(1);
      end
      r_count <= r_count + CWIDTH'(w_push) - CWIDTH'(w_pop);
    end
  end

  // A drop in the same cycle as a clear survives the clear as the first new loss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= 8'd0;
    end else if (clear_ovf) begin
      r_overflow  <= w_drop;
      r_dropCount <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCount != 8'hFF) begin
        r_dropCount <= r_dropCount + 8'd1;
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rdPtr] : '0;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Scoreboard bench for pipe_out_fifo: a queue model predicts occupancy, head word and
// drop bookkeeping each cycle; a small increment pipeline feeds the streaming phase.
module tb_pipe_out_fifo;

  localparam int DWIDTH = 4;
  localparam int DEPTH  = 4;
  localparam int CWIDTH = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [CWIDTH-1:0] count;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              clear_ovf;

  logic              drvValid;
  logic [DWIDTH-1:0] drvData;
  logic              usePipe;
  logic              pipeInValid;
  logic [DWIDTH-1:0] pipeIn;
  logic [DWIDTH-1:0] pX;
  logic [DWIDTH-1:0] pY;
  logic [DWIDTH-1:0] pZ;
  logic [2:0]        pV;

  int vectors = 0;
  int miscompares = 0;

  logic [DWIDTH-1:0] expQ[$];
  logic [DWIDTH-1:0] streamQ[$];
  logic              mOvf;
  logic [7:0]        mDc;

  pipe_out_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upstream increment pipeline: in -> x -> y -> z, z = in + 2 three edges later.
  always @(posedge clock) begin
    if (reset) begin
      pV <= '0;
      pX <= '0;
      pY <= '0;
      pZ <= '0;
    end else begin
      pV <= {pV[1:0], pipeInValid};
      pX <= pipeIn;
      pY <= pX + 4'd1;
      pZ <= pY + 4'd1;
    end
  end

  assign in_valid = usePipe ? pV[2] : drvValid;
  assign in_data  = usePipe ? pZ : drvData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkState(input string phase);
    checkOutput({phase, ".out_valid"}, 32'(out_valid), 32'(expQ.size() != 0));
    checkOutput({phase, ".count"}, 32'(count), 32'(expQ.size()));
    checkOutput({phase, ".out_data"}, 32'(out_data), (expQ.size() != 0) ? 32'(expQ[0]) : 32'd0);
    checkOutput({phase, ".overflow"}, 32'(overflow), 32'(mOvf));
    checkOutput({phase, ".drop_count"}, 32'(drop_count), 32'(mDc));
  endtask

  // Called just after a falling edge: drive, check the registered outputs, advance the model.
  task automatic applyStimulus(input logic v, input logic [DWIDTH-1:0] d, input logic rdy,
                               input logic clr);
    logic pop, push, drop, full;
    drvValid  = v;
    drvData   = d;
    out_ready = rdy;
    clear_ovf = clr;
    #1;
    checkState("step");
    full = (expQ.size() == DEPTH);
    pop  = (expQ.size() != 0) && rdy;
    push = v && (!full || pop);
    drop = v && full && !pop;
    @(posedge clock);
    if (pop) void'(expQ.pop_front());
    if (push) expQ.push_back(d);
    if (clr) begin
      mOvf = drop;
      mDc  = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      mOvf = 1'b1;
      if (mDc != 8'hFF) mDc = mDc + 8'd1;
    end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstSeen;
    reset       = 1'b1;
    drvValid    = 1'b0;
    drvData     = '0;
    out_ready   = 1'b0;
    clear_ovf   = 1'b0;
    usePipe     = 1'b0;
    pipeInValid = 1'b0;
    pipeIn      = '0;
    mOvf        = 1'b0;
    mDc         = 8'd0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checkState("reset");
    reset = 1'b0;

    $display("[TB] idle after reset, in_data ignored without in_valid");
    applyStimulus(1'b0, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h7, 1'b0, 1'b0);

    $display("[TB] fill with backpressure");
    for (int i = 2; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("fullCount", 32'(count), 32'd4);
    checkOutput("fullHead", 32'(out_data), 32'h2);

    $display("[TB] overflow and clear");
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    checkOutput("ovfDrops", 32'(drop_count), 32'd2);
    checkOutput("ovfHeadKept", 32'(out_data), 32'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("dropClearFlag", 32'(overflow), 32'd1);
    checkOutput("dropClearCount", 32'(drop_count), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

    $display("[TB] push and pop together while full, then drain");
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
    drvValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("asyncRst.out_data", 32'(out_data), 32'd0);
    checkOutput("asyncRst.count", 32'(count), 32'd0);
    checkOutput("asyncRst.overflow", 32'(overflow), 32'd0);
    checkOutput("asyncRst.drop_count", 32'(drop_count), 32'd0);
    expQ.delete();
    mOvf = 1'b0;
    mDc  = 8'd0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h6, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

    $display("[TB] streaming from the increment pipeline");
    usePipe   = 1'b1;
    out_ready = 1'b1;
    clear_ovf = 1'b0;
    firstSeen = -1;
    for (int k = 0; k < 24; k++) begin
      pipeInValid = (k < 16);
      pipeIn      = 4'(k);
      if (k < 16) streamQ.push_back(4'(k + 2));
      @(posedge clock);
      @(negedge clock);
      checkOutput("streamCountLe1", 32'(count <= 1), 32'd1);
      if (out_valid) begin
        if (firstSeen < 0) begin
          firstSeen = k + 1;
          checkOutput("streamLatency", 32'(firstSeen), 32'd4);
        end
        if (streamQ.size() != 0) checkOutput("streamData", 32'(out_data), 32'(streamQ.pop_front()));
        else checkOutput("streamExtraWord", 32'(out_valid), 32'd0);
      end
    end
    pipeInValid = 1'b0;
    usePipe     = 1'b0;
    checkOutput("streamLeft", 32'(streamQ.size()), 32'd0);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 4), 1'b0, 1'b0);
    repeat (300) applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("satDropCount", 32'(drop_count), 32'd255);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

    $display("[TB] pointer wrap with paired push/pop");
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) applyStimulus(1'b1, 4'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 7) == 0));
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
